// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline request/response handshake and the data-memory port
// seen by mem_access_unit.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; req_ready is high only while the unit is idle and
// req_valid is ignored otherwise. Completion is a single-cycle resp_valid
// pulse with no back-pressure; resp_rdata/resp_err stay stable until the
// next response or reset.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [1:0]        req_size;
  logic              req_rw;
  logic              req_signed;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_A;
  logic [31:0]       mem_DI;
  logic [31:0]       mem_DO;
  logic [1:0]        mem_Size;
  logic              mem_RW;
  logic              mem_E;

  // View of the load/store unit itself
  modport slave (
    input  req_valid, req_addr, req_wdata, req_size, req_rw, req_signed, mem_DO,
    output req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_A, mem_DI, mem_Size, mem_RW, mem_E
  );

  // View of the environment: pipeline MEM stage plus data memory
  modport master (
    output req_valid, req_addr, req_wdata, req_size, req_rw, req_signed, mem_DO,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy,
           mem_A, mem_DI, mem_Size, mem_RW, mem_E
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of a big-endian byte-addressed data memory.
// Aligned accesses use one memory cycle; misaligned halfwords/words are split
// into byte beats, most significant byte first. Loads are assembled and
// zero/sign-extended; illegal size or out-of-range accesses answer with an
// error and never touch the memory.
module mem_access_unit #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave bus,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, ERR = 2'd3} state_e;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(MEM_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              rw_q, rw_d;
  logic              signed_q, signed_d;
  logic              split_q, split_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        last_q, last_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [2:0]        req_nbytes;
  logic              req_misaligned;
  logic [ADDR_W:0]   req_end;
  logic              req_bad;
  logic [31:0]       asm_next;
  logic [4:0]        byte_shift;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                         input logic sg);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {{24{sg & v[7]}}, v[7:0]};
      2'b01:   r = {{16{sg & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Decode the live request: byte count, alignment and range check. The end
  // address is computed one bit wider so address wrap-around reads as out of range.
  always_comb begin
    req_nbytes     = 3'd1;
    req_misaligned = 1'b0;
    case (bus.req_size)
      2'b01: begin
        req_nbytes     = 3'd2;
        req_misaligned = bus.req_addr[0];
      end
      2'b10: begin
        req_nbytes     = 3'd4;
        req_misaligned = |bus.req_addr[1:0];
      end
      default: ;
    endcase
    req_end = {1'b0, bus.req_addr} + (ADDR_W + 1)'(req_nbytes) - (ADDR_W + 1)'(1);
    req_bad = (bus.req_size == 2'b11) || (req_end > LAST_ADDR);
  end

  // Split beats shift one byte into the assembly register; aligned beats take the whole word.
  assign asm_next   = split_q ? {asm_q[23:0], bus.mem_DO[7:0]} : bus.mem_DO;
  // Beat k of a split store carries the k-th byte counted from the MSB of the right-justified data.
  assign byte_shift = {last_q - beat_q, 3'b000};

  // Next-state and memory-port logic; memory port sits at zero outside ACCESS.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    rw_d         = rw_q;
    signed_d     = signed_q;
    split_d      = split_q;
    beat_d       = beat_q;
    last_d       = last_q;
    asm_d        = asm_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    bus.mem_A    = '0;
    bus.mem_DI   = '0;
    bus.mem_Size = 2'b00;
    bus.mem_RW   = 1'b0;
    bus.mem_E    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          size_d   = bus.req_size;
          rw_d     = bus.req_rw;
          signed_d = bus.req_signed;
          split_d  = req_misaligned;
          last_d   = req_misaligned ? 2'(req_nbytes - 3'd1) : 2'd0;
          beat_d   = 2'd0;
          asm_d    = '0;
          if (req_bad) begin
            state_d = ERR;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        bus.mem_A  = addr_q + ADDR_W'(beat_q);
        bus.mem_RW = rw_q;
        bus.mem_E  = rw_q;
        if (split_q) begin
          bus.mem_Size = 2'b00;
          bus.mem_DI   = {24'd0, 8'(wdata_q >> byte_shift)};
        end else begin
          bus.mem_Size = size_q;
          case (size_q)
            2'b00:   bus.mem_DI = {24'd0, wdata_q[7:0]};
            2'b01:   bus.mem_DI = {16'd0, wdata_q[15:0]};
            default: bus.mem_DI = wdata_q;
          endcase
        end
        if (!rw_q) asm_d = asm_next;
        if (beat_q == last_q) begin
          state_d = RESP;
          rdata_d = rw_q ? 32'd0 : extend(asm_next, size_q, signed_q);
          err_d   = 1'b0;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request/assembly/response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= 2'b00;
      rw_q     <= 1'b0;
      signed_q <= 1'b0;
      split_q  <= 1'b0;
      beat_q   <= 2'd0;
      last_q   <= 2'd0;
      asm_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      rw_q     <= rw_d;
      signed_q <= signed_d;
      split_q  <= split_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      asm_q    <= asm_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = (state_q == RESP) || (state_q == ERR);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a behavioural big-endian memory sits on the
// memory port, and a byte-array reference model predicts each response,
// its latency and the resulting memory contents.
module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus();

  mem_access_unit #(.MEM_BYTES(256), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state_dbg_o (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory and reference ----------------
  logic [7:0] mem [256];
  logic [7:0] init_val [256];
  logic [7:0] ref_mem [256];
  logic       fill_mem = 1'b0;

  always_comb begin
    bus.mem_DO = '0;
    case (bus.mem_Size)
      2'b00: bus.mem_DO = {24'd0, mem[bus.mem_A[7:0]]};
      2'b01: bus.mem_DO = {16'd0, mem[bus.mem_A[7:0]], mem[8'(bus.mem_A[7:0] + 8'd1)]};
      default: bus.mem_DO = {mem[bus.mem_A[7:0]], mem[8'(bus.mem_A[7:0] + 8'd1)],
                             mem[8'(bus.mem_A[7:0] + 8'd2)], mem[8'(bus.mem_A[7:0] + 8'd3)]};
    endcase
  end

  always @(posedge clk) begin
    if (fill_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val[i];
    end else if (bus.mem_E) begin
      case (bus.mem_Size)
        2'b00: mem[bus.mem_A[7:0]] <= bus.mem_DI[7:0];
        2'b01: begin
          mem[bus.mem_A[7:0]]               <= bus.mem_DI[15:8];
          mem[8'(bus.mem_A[7:0] + 8'd1)]    <= bus.mem_DI[7:0];
        end
        default: begin
          mem[bus.mem_A[7:0]]               <= bus.mem_DI[31:24];
          mem[8'(bus.mem_A[7:0] + 8'd1)]    <= bus.mem_DI[23:16];
          mem[8'(bus.mem_A[7:0] + 8'd2)]    <= bus.mem_DI[15:8];
          mem[8'(bus.mem_A[7:0] + 8'd3)]    <= bus.mem_DI[7:0];
        end
      endcase
    end
  end

  // ---------------- observation from the last transaction ----------------
  logic [31:0] tr_a [$];
  logic [31:0] tr_di [$];
  logic [1:0]  tr_size [$];
  logic        tr_e [$];
  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_mem(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, 32'(diffs), 32'd0);
  endtask

  // Issue one request, follow it to its response and compare against the model.
  task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic rw, input logic sg,
                        input bit noise);
    int          n;
    bit          bad;
    bit          mis;
    int          exp_lat;
    int          exp_beats;
    logic [31:0] exp_rd;
    logic [31:0] v;
    bit          got;
    int          e_cnt;
    logic [31:0] held;

    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad = (sz == 2'b11) || (({32'd0, a} + 64'(n) - 64'd1) > 64'd255);
    mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    exp_lat   = bad ? 1 : (mis ? 1 + n : 2);
    exp_beats = bad ? 0 : (mis ? n : 1);
    exp_rd    = 32'd0;
    if (!bad && !rw) begin
      v = 32'd0;
      for (int i = 0; i < n; i++) v = (v << 8) | {24'd0, ref_mem[8'(a + 32'(i))]};
      if (sg && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
      if (sg && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      exp_rd = v;
    end
    if (!bad && rw) begin
      for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = 8'(wd >> (8 * (n - 1 - i)));
    end

    tr_a.delete(); tr_di.delete(); tr_size.delete(); tr_e.delete();
    @(negedge clk);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_size   = sz;
    bus.req_rw     = rw;
    bus.req_signed = sg;
    @(posedge clk);
    #1;
    // Optional junk request while busy; it must be ignored.
    bus.req_valid = noise ? 1'b1 : 1'b0;
    if (noise) begin
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_size  = 2'($urandom_range(0, 3));
      bus.req_rw    = 1'($urandom_range(0, 1));
    end

    got = 1'b0;
    got_lat = 0;
    e_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1;
        got_lat = c;
        break;
      end
      tr_a.push_back(bus.mem_A);
      tr_di.push_back(bus.mem_DI);
      tr_size.push_back(bus.mem_Size);
      tr_e.push_back(bus.mem_E);
      if (bus.mem_E) e_cnt++;
      check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    end
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    got_rdata = bus.resp_rdata;
    got_err   = bus.resp_err;
    check({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
    check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    check({tag, "_err"}, {31'd0, bus.resp_err}, {31'd0, bad});
    check({tag, "_ready_in_resp"}, {31'd0, bus.req_ready}, 32'd0);
    check({tag, "_beats"}, 32'(tr_a.size()), 32'(exp_beats));
    check({tag, "_we_cycles"}, 32'(e_cnt), rw ? 32'(exp_beats) : 32'd0);
    held = bus.resp_rdata;

    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, "_pulse_end"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, "_rdata_hold"}, bus.resp_rdata, held);
    check_mem({tag, "_mem"});
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [7:0]  exp_b [4];
    logic [31:0] ra;
    logic [1:0]  rs;
    int          r;

    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_size   = 2'b00;
    bus.req_rw     = 1'b0;
    bus.req_signed = 1'b0;
    for (int i = 0; i < 256; i++) begin
      init_val[i] = 8'($urandom);
      ref_mem[i]  = init_val[i];
    end

    // Reset with memory preload
    fill_mem = 1'b1;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    fill_mem = 1'b0;
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, bus.resp_err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mem_A", bus.mem_A, 32'd0);
    check("rst_mem_DI", bus.mem_DI, 32'd0);
    check("rst_mem_Size", {30'd0, bus.mem_Size}, 32'd0);
    check("rst_mem_RW", {31'd0, bus.mem_RW}, 32'd0);
    check("rst_mem_E", {31'd0, bus.mem_E}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // 1: aligned word load
    do_req("t1_st", 32'h10, 32'h1122_3344, 2'b10, 1'b1, 1'b0, 1'b0);
    do_req("t1_ld", 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    check("t1_value", got_rdata, 32'h1122_3344);
    check("t1_A", tr_a.size() > 0 ? tr_a[0] : 32'hDEAD_BEEF, 32'h10);
    check("t1_Size", tr_size.size() > 0 ? {30'd0, tr_size[0]} : 32'hDEAD_BEEF, 32'd2);
    check("t1_lat", 32'(got_lat), 32'd2);

    // 2: byte load signed / unsigned
    do_req("t2_st", 32'h05, 32'h0000_0080, 2'b00, 1'b1, 1'b0, 1'b0);
    do_req("t2_lds", 32'h05, 32'h0, 2'b00, 1'b0, 1'b1, 1'b0);
    check("t2_signed", got_rdata, 32'hFFFF_FF80);
    do_req("t2_ldu", 32'h05, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0);
    check("t2_unsigned", got_rdata, 32'h0000_0080);

    // 3: misaligned word store split into four byte beats
    do_req("t3_st", 32'h21, 32'hAABB_CCDD, 2'b10, 1'b1, 1'b0, 1'b0);
    check("t3_lat", 32'(got_lat), 32'd5);
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    if (tr_a.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t3_A%0d", k), tr_a[k], 32'h21 + 32'(k));
        check($sformatf("t3_DI%0d", k), tr_di[k], {24'd0, exp_b[k]});
        check($sformatf("t3_Size%0d", k), {30'd0, tr_size[k]}, 32'd0);
        check($sformatf("t3_E%0d", k), {31'd0, tr_e[k]}, 32'd1);
      end
    end
    do_req("t3_ld", 32'h21, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    check("t3_value", got_rdata, 32'hAABB_CCDD);

    // 4: misaligned signed half load
    do_req("t4_st0", 32'h03, 32'h7F, 2'b00, 1'b1, 1'b0, 1'b0);
    do_req("t4_st1", 32'h04, 32'h01, 2'b00, 1'b1, 1'b0, 1'b0);
    do_req("t4_ld", 32'h03, 32'h0, 2'b01, 1'b0, 1'b1, 1'b0);
    check("t4_value", got_rdata, 32'h0000_7F01);
    check("t4_lat", 32'(got_lat), 32'd3);

    // 5: errors: out of range, illegal size, wrap-around
    do_req("t5_oor_ld", 32'hFE, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0);
    check("t5_oor_err", {31'd0, got_err}, 32'd1);
    check("t5_oor_lat", 32'(got_lat), 32'd1);
    do_req("t5_oor_st", 32'hFE, 32'h1234_5678, 2'b10, 1'b1, 1'b0, 1'b0);
    do_req("t5_sz3_ld", 32'h10, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0);
    do_req("t5_sz3_st", 32'h10, 32'hFFFF_FFFF, 2'b11, 1'b1, 1'b0, 1'b0);
    check("t5_sz3_err", {31'd0, got_err}, 32'd1);
    do_req("t5_wrap", 32'hFFFF_FFFF, 32'h0, 2'b01, 1'b0, 1'b0, 1'b0);
    do_req("t5_byte_last", 32'hFF, 32'h5A, 2'b00, 1'b1, 1'b0, 1'b0);

    // 6: reset during a split word store (at 0x41) after its first two beats
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h41;
    bus.req_wdata  = 32'h5566_7788;
    bus.req_size   = 2'b10;
    bus.req_rw     = 1'b1;
    bus.req_signed = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    ref_mem[8'h41] = 8'h55;
    ref_mem[8'h42] = 8'h66;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 1) rst_n = 1'b1;
      check($sformatf("t6_no_resp%0d", c), {31'd0, bus.resp_valid}, 32'd0);
      check($sformatf("t6_no_we%0d", c), {31'd0, bus.mem_E}, 32'd0);
      check($sformatf("t6_idle%0d", c), {31'd0, bus.busy}, 32'd0);
    end
    check("t6_ready", {31'd0, bus.req_ready}, 32'd1);
    check_mem("t6_partial_mem");

    // Random traffic with ignored requests while busy
    for (int t = 0; t < 60; t++) begin
      r  = $urandom_range(0, 9);
      rs = (r == 0) ? 2'b11 : 2'(r % 3);
      ra = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                       : 32'($urandom_range(0, 259));
      do_req($sformatf("rnd%0d", t), ra, $urandom, rs, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
